// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Owns the CPU's single memory port and shares it between instruction fetch
// (FE), load/store (LS) and the internal OAM DMA engine. Only one memory
// transaction is outstanding at any time, and every memory-side output comes
// straight from a flop.
//
// An LS write to DMA_REG_ADDR is swallowed here and is not forwarded to memory.
// It starts a DMA_LEN-byte copy from page {wdata,8'h00} into OAM_DATA_ADDR,
// one read followed by one write per byte. The CPU is stalled for the whole
// copy.
//
// Optional build macro:
//   OAM_DMA_ALIGN_EN - adds a free-running parity bit. When parity is 1 in the
//                      first alignment cycle, the DMA spends one extra cycle in
//                      DMA_ALIGN (odd-cycle alignment). Without the macro there
//                      is exactly one alignment cycle and no parity flop.
//
// Ports:
//   clk_i, rstn_i               clock, asynchronous active-low reset
//   fe_req_i/fe_addr_i          fetch read request (held until fe_gnt_o)
//   fe_gnt_o/fe_rvalid_o        fetch accept pulse / read-data-valid pulse
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i
//                               load/store request (held until ls_gnt_o)
//   ls_gnt_o/ls_rvalid_o        LS accept pulse / read-data-valid pulse
//   rdata_o                     last CPU read data, held until the next read
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o
//                               registered memory request
//   mem_valid_i/mem_rdata_i     memory completion and read data
//   cpu_stall_o, dma_busy_o     high while a DMA copy is in progress
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int                ADDR_W        = 16,
  parameter int                DATA_W        = 8,
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = 16'h2004,
  parameter int                DMA_LEN       = 256
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              fe_req_i,
  input  logic [ADDR_W-1:0] fe_addr_i,
  output logic              fe_gnt_o,
  output logic              fe_rvalid_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_stall_o,
  output logic              dma_busy_o
);

  localparam int              IDX_W    = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
  localparam int              PAGE_W   = ADDR_W - 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_DMA_ALIGN,
    S_DMA_RD,
    S_DMA_RD_WAIT,
    S_DMA_WR_WAIT
  } state_e;

  typedef enum logic {
    OWN_FE,
    OWN_LS
  } owner_e;

  // Source address of DMA byte idx inside the selected page.
  function automatic logic [ADDR_W-1:0] dma_src_addr(input logic [PAGE_W-1:0] page,
                                                      input logic [IDX_W-1:0]  idx);
    return {page, 8'(idx)};
  endfunction

  state_e              state_q,     state_d;
  owner_e              owner_q,     owner_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [PAGE_W-1:0]   page_q,      page_d;
  logic                fe_gnt_q,    fe_gnt_d;
  logic                ls_gnt_q,    ls_gnt_d;
  logic                fe_rvalid_q, fe_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q,      busy_d;
  logic                issue_rd;
`ifdef OAM_DMA_ALIGN_EN
  logic                parity_q,      parity_d;
  logic                align_first_q, align_first_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    idx_d       = idx_q;
    page_d      = page_q;
    fe_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    fe_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    issue_rd    = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
    parity_d      = ~parity_q;
    align_first_d = align_first_q;
`endif

    case (state_q)
      // The DMA trigger jumps straight to DMA_ALIGN, so a pending DMA always
      // beats the CPU masters; among those LS wins over FE.
      S_IDLE: begin
        if (ls_req_i) begin
          ls_gnt_d = 1'b1;
          if (ls_we_i && (ls_addr_i == DMA_REG_ADDR)) begin
            // Trigger register write never reaches memory.
            page_d  = PAGE_W'(ls_wdata_i);
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_DMA_ALIGN;
`ifdef OAM_DMA_ALIGN_EN
            align_first_d = 1'b1;
`endif
          end else begin
            owner_d     = OWN_LS;
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
            state_d     = S_BUSY;
          end
        end else if (fe_req_i) begin
          fe_gnt_d    = 1'b1;
          owner_d     = OWN_FE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = fe_addr_i;
          mem_wdata_d = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_valid_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata_i;
            if (owner_q == OWN_FE) fe_rvalid_d = 1'b1;
            else                   ls_rvalid_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      S_DMA_ALIGN: begin
`ifdef OAM_DMA_ALIGN_EN
        // Odd parity on the first alignment cycle buys one more idle cycle.
        align_first_d = 1'b0;
        if (align_first_q && parity_q) state_d = S_DMA_ALIGN;
        else                           issue_rd = 1'b1;
`else
        issue_rd = 1'b1;
`endif
      end

      // Gap cycle between the write of one byte and the read of the next.
      S_DMA_RD: begin
        issue_rd = 1'b1;
      end

      // The byte read is latched directly into the write-data flop and the
      // write to OAM is issued on the same edge.
      S_DMA_RD_WAIT: begin
        if (mem_valid_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = OAM_DATA_ADDR;
          mem_wdata_d = mem_rdata_i;
          state_d     = S_DMA_WR_WAIT;
        end
      end

      S_DMA_WR_WAIT: begin
        if (mem_valid_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_DMA_RD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue_rd) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = dma_src_addr(page_q, idx_q);
      state_d    = S_DMA_RD_WAIT;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FE;
      idx_q       <= '0;
      page_q      <= '0;
      fe_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      fe_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity_q      <= 1'b0;
      align_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      fe_gnt_q    <= fe_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      fe_rvalid_q <= fe_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef OAM_DMA_ALIGN_EN
      parity_q      <= parity_d;
      align_first_q <= align_first_d;
`endif
    end
  end

  assign fe_gnt_o    = fe_gnt_q;
  assign ls_gnt_o    = ls_gnt_q;
  assign fe_rvalid_o = fe_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_stall_o = busy_q;
  assign dma_busy_o  = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for mem_bus_arbiter: directed scenarios followed by randomized FE/LS
// traffic. An external memory with random latency logs every completed access.
// A reference model predicts the expected access list and read data from a
// shadow memory array.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        fe_req_i = 1'b0;
  logic [15:0] fe_addr_i = '0;
  logic        fe_gnt_o, fe_rvalid_o;
  logic        ls_req_i = 1'b0;
  logic        ls_we_i = 1'b0;
  logic [15:0] ls_addr_i = '0;
  logic [7:0]  ls_wdata_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [7:0]  rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_valid_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        cpu_stall_o, dma_busy_o;

  mem_bus_arbiter dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .fe_req_i(fe_req_i), .fe_addr_i(fe_addr_i), .fe_gnt_o(fe_gnt_o), .fe_rvalid_o(fe_rvalid_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .cpu_stall_o(cpu_stall_o), .dma_busy_o(dma_busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [24:0] log_q [$];   // {we, addr, wdata(0 for reads)} per completed access
  logic [7:0]  fe_rq [$];
  logic [7:0]  ls_rq [$];
  int          lat_fixed = 0;   // negative: random latency 0..3
  int          mcnt = 0;
  int          mlat = 0;
  int          checks = 0;
  int          errors = 0;

  // External memory plus read-data monitors, all evaluated on the falling edge.
  always @(negedge clk_i) begin
    if (fe_rvalid_o) fe_rq.push_back(rdata_o);
    if (ls_rvalid_o) ls_rq.push_back(rdata_o);
    if (!rstn_i) begin
      mem_valid_i = 1'b0;
      mem_rdata_i = '0;
      mcnt = 0;
    end else begin
      if (mem_valid_i) mcnt = 0;
      if (mem_req_o) begin
        if (mcnt == 0) mlat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        if (mcnt >= mlat) begin
          mem_valid_i = 1'b1;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = 8'($urandom);
            log_q.push_back({1'b1, mem_addr_o, mem_wdata_o});
          end else begin
            mem_rdata_i = mem[mem_addr_o];
            log_q.push_back({1'b0, mem_addr_o, 8'h00});
          end
        end else begin
          mem_valid_i = 1'b0;
          mem_rdata_i = 8'($urandom);
        end
        mcnt++;
      end else begin
        mem_valid_i = 1'b0;
        mcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({fe_gnt_o, fe_rvalid_o, ls_gnt_o, ls_rvalid_o, cpu_stall_o, dma_busy_o,
                mem_req_o, mem_we_o, rdata_o, mem_wdata_o, mem_addr_o});
  endfunction

  // Issue FE and/or LS requests together; LS is expected to be served first.
  task automatic run_ops(input bit do_fe, input logic [15:0] fa, input bit do_ls,
                         input bit lwe, input logic [15:0] la, input logic [7:0] lwd);
    logic [24:0] exp_q [$];
    logic [7:0]  fe_exp, ls_exp;
    int lb, fb, sb, n_fe, n_ls;
    bit ok;
    lb = log_q.size(); fb = fe_rq.size(); sb = ls_rq.size();
    n_fe = 0; n_ls = 0; fe_exp = '0; ls_exp = '0;
    if (do_ls) begin
      if (lwe) begin
        exp_q.push_back({1'b1, la, lwd});
        ref_mem[la] = lwd;
      end else begin
        exp_q.push_back({1'b0, la, 8'h00});
        ls_exp = ref_mem[la];
        n_ls = 1;
      end
    end
    if (do_fe) begin
      exp_q.push_back({1'b0, fa, 8'h00});
      fe_exp = ref_mem[fa];
      n_fe = 1;
    end
    fe_addr_i = fa; ls_we_i = lwe; ls_addr_i = la; ls_wdata_i = lwd;
    fe_req_i = do_fe; ls_req_i = do_ls;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (fe_gnt_o) fe_req_i = 1'b0;
      if (ls_gnt_o) ls_req_i = 1'b0;
      if (!fe_req_i && !ls_req_i && log_q.size() == lb + exp_q.size() &&
          fe_rq.size() == fb + n_fe && ls_rq.size() == sb + n_ls) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    fe_req_i = 1'b0; ls_req_i = 1'b0;
    check("ops_done", 64'(ok), 64'(1));
    check("ops_log_len", 64'(log_q.size() - lb), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (lb + i < log_q.size()) check("ops_txn", 64'(log_q[lb + i]), 64'(exp_q[i]));
    check("ops_fe_rv_cnt", 64'(fe_rq.size() - fb), 64'(n_fe));
    check("ops_ls_rv_cnt", 64'(ls_rq.size() - sb), 64'(n_ls));
    if (n_fe == 1 && fe_rq.size() > fb) check("ops_fe_data", 64'(fe_rq[fb]), 64'(fe_exp));
    if (n_ls == 1 && ls_rq.size() > sb) check("ops_ls_data", 64'(ls_rq[sb]), 64'(ls_exp));
  endtask

  initial begin
    int lb, fb, sb, first_req, last_w, busy_low, bad_gnt, busy_hi;
    bit hit;
    logic [15:0] fa, la;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h8000] = 8'hA9; ref_mem[16'h8000] = 8'hA9;

    // Reset state
    step(); step();
    check("reset_outputs", outs(), 64'(0));
    rstn_i = 1'b1;
    step();
    check("idle_after_reset", outs(), 64'(0));

    // Single FE read, zero wait
    lat_fixed = 0;
    fe_addr_i = 16'h8000; fe_req_i = 1'b1;
    step();
    check("fe_gnt_c1", 64'(fe_gnt_o), 64'(1));
    check("fe_mem_c1", 64'({mem_req_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b0, 16'h8000}));
    fe_req_i = 1'b0;
    step();
    check("fe_c2_ctrl", 64'({fe_gnt_o, mem_req_o, fe_rvalid_o}), 64'(3'b001));
    check("fe_c2_rdata", 64'(rdata_o), 64'(8'hA9));
    step();
    check("fe_c3_rvalid_low", 64'(fe_rvalid_o), 64'(0));

    // FE and LS on the same edge: LS first, FE two cycles later
    fe_addr_i = 16'h8001; fe_req_i = 1'b1;
    ls_we_i = 1'b0; ls_addr_i = 16'h0010; ls_req_i = 1'b1;
    step();
    check("prio_ls_gnt", 64'({ls_gnt_o, fe_gnt_o}), 64'(2'b10));
    check("prio_ls_addr", 64'(mem_addr_o), 64'(16'h0010));
    ls_req_i = 1'b0;
    step();
    check("prio_ls_rvalid", 64'({ls_rvalid_o, fe_gnt_o}), 64'(2'b10));
    check("prio_ls_data", 64'(rdata_o), 64'(ref_mem[16'h0010]));
    step();
    check("prio_fe_gnt", 64'(fe_gnt_o), 64'(1));
    check("prio_fe_addr", 64'(mem_addr_o), 64'(16'h8001));
    fe_req_i = 1'b0;
    step();
    check("prio_fe_data", 64'({fe_rvalid_o, rdata_o}), 64'({1'b1, ref_mem[16'h8001]}));

    // LS write with three wait cycles
    lat_fixed = 3;
    sb = ls_rq.size(); lb = log_q.size();
    ls_we_i = 1'b1; ls_addr_i = 16'h0200; ls_wdata_i = 8'h55; ls_req_i = 1'b1;
    ref_mem[16'h0200] = 8'h55;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        check("lsw_gnt", 64'(ls_gnt_o), 64'(1));
        ls_req_i = 1'b0;
      end
      check("lsw_stable", 64'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
            64'({1'b1, 1'b1, 16'h0200, 8'h55}));
    end
    step();
    check("lsw_released", 64'(mem_req_o), 64'(0));
    step();
    check("lsw_no_rvalid", 64'(ls_rq.size() - sb), 64'(0));
    check("lsw_one_txn", 64'(log_q.size() - lb), 64'(1));
    check("lsw_rdata_held", 64'(rdata_o), 64'(ref_mem[16'h8001]));
    check("lsw_mem", 64'(mem[16'h0200]), 64'(8'h55));

    // OAM DMA from page 0x02 with an FE request parked during the copy
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      ref_mem[16'h0200 + i] = 8'(i);
    end
    lat_fixed = -1;
    lb = log_q.size(); fb = fe_rq.size(); sb = ls_rq.size();
    ls_we_i = 1'b1; ls_addr_i = 16'h4014; ls_wdata_i = 8'h02; ls_req_i = 1'b1;
    step();
    check("dma_trig_gnt", 64'(ls_gnt_o), 64'(1));
    check("dma_trig_no_mem", 64'(mem_req_o), 64'(0));
    check("dma_busy_on", 64'({dma_busy_o, cpu_stall_o}), 64'(2'b11));
    ls_req_i = 1'b0;
    fe_addr_i = 16'h9000; fe_req_i = 1'b1;
    first_req = -1; last_w = -1; busy_low = -1; bad_gnt = 0;
    for (int k = 2; k < 4000; k++) begin
      step();
      if (fe_gnt_o) bad_gnt++;
      if (first_req < 0 && mem_req_o) first_req = k;
      if (last_w < 0 && log_q.size() >= lb + 512) last_w = k;
      if (!dma_busy_o) begin
        busy_low = k;
        break;
      end
    end
    lat_fixed = 0;
`ifdef OAM_DMA_ALIGN_EN
    check("dma_first_rd", 64'(first_req == 2 || first_req == 3), 64'(1));
`else
    check("dma_first_rd", 64'(first_req), 64'(2));
`endif
    check("dma_finished", 64'(busy_low > 0), 64'(1));
    check("dma_stall_drop", 64'(busy_low - last_w), 64'(1));
    check("dma_stall_low", 64'(cpu_stall_o), 64'(0));
    check("dma_fe_blocked", 64'(bad_gnt), 64'(0));
    check("dma_log_len", 64'(log_q.size() - lb), 64'(512));
    for (int i = 0; i < 256; i++) begin
      if (lb + 2 * i + 1 < log_q.size()) begin
        check("dma_rd", 64'(log_q[lb + 2 * i]), 64'({1'b0, 16'h0200 + 16'(i), 8'h00}));
        check("dma_wr", 64'(log_q[lb + 2 * i + 1]), 64'({1'b1, 16'h2004, ref_mem[16'h0200 + 16'(i)]}));
      end
    end
    ref_mem[16'h2004] = ref_mem[16'h02FF];
    check("dma_no_rvalid", 64'((fe_rq.size() - fb) + (ls_rq.size() - sb)), 64'(0));
    step();
    check("dma_fe_gnt_after", 64'(fe_gnt_o), 64'(1));
    check("dma_fe_addr_after", 64'(mem_addr_o), 64'(16'h9000));
    fe_req_i = 1'b0;
    step();
    check("dma_fe_data_after", 64'({fe_rvalid_o, rdata_o}), 64'({1'b1, ref_mem[16'h9000]}));

    // Reset in the middle of a DMA copy (page 0x03)
    lb = log_q.size();
    ls_we_i = 1'b1; ls_addr_i = 16'h4014; ls_wdata_i = 8'h03; ls_req_i = 1'b1;
    step();
    ls_req_i = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (log_q.size() >= lb + 201) begin
        hit = 1'b1;
        break;
      end
    end
    check("dma_reached_byte100", 64'(hit), 64'(1));
    check("dma_busy_mid", 64'(dma_busy_o), 64'(1));
    rstn_i = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 64'(0));
    step(); step();
    rstn_i = 1'b1;
    step();
    lb = log_q.size();
    run_ops(1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 8'h00);
    busy_hi = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dma_busy_o || mem_req_o) busy_hi++;
    end
    check("no_dma_resume", 64'(busy_hi), 64'(0));
    check("post_reset_one_txn", 64'(log_q.size() - lb), 64'(1));

    // Randomized FE/LS traffic with random memory latency
    lat_fixed = -1;
    for (int it = 0; it < 40; it++) begin
      fa = {1'b1, 15'($urandom)};
      la = {5'b0, 11'($urandom)};
      case ($urandom_range(0, 4))
        0: run_ops(1'b1, fa, 1'b0, 1'b0, la, 8'h00);
        1: run_ops(1'b0, fa, 1'b1, 1'b0, la, 8'h00);
        2: run_ops(1'b0, fa, 1'b1, 1'b1, la, 8'($urandom));
        3: run_ops(1'b1, fa, 1'b1, 1'($urandom), la, 8'($urandom));
        default: run_ops(1'b1, la, 1'b1, 1'b1, la, 8'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the CPU's single memory port and shares it between three masters: instruction fetch (FE), load/store (LS) and an internal OAM DMA engine.
- Sits between fetch/control and external memory.
- A write to the DMA trigger register starts a 256-byte copy from page {wdata,8'h00} to OAM_DATA_ADDR; CPU stall is requested while it runs.
- One outstanding transaction at a time; all memory-side outputs registered.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
DMA_REG_ADDR, 16'h4014, LS write to this address triggers OAM DMA (consumed internally, not forwarded)
OAM_DATA_ADDR, 16'h2004, DMA write target
DMA_LEN, 256, bytes per DMA

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
fe_req_i  in  1  fetch read request, held until fe_gnt_o
fe_addr_i  in  ADDR_W  fetch address
fe_gnt_o  out  1  one-cycle pulse, FE request accepted
fe_rvalid_o  out  1  one-cycle pulse, rdata_o holds FE read data
ls_req_i  in  1  load/store request, held until ls_gnt_o
ls_we_i  in  1  1=write
ls_addr_i  in  ADDR_W  LS address
ls_wdata_i  in  DATA_W  LS write data
ls_gnt_o  out  1  one-cycle pulse, LS request accepted
ls_rvalid_o  out  1  one-cycle pulse, LS read data valid (reads only)
rdata_o  out  DATA_W  returned read data, held until next read completes
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_valid_i  in  1  access complete this cycle (read data valid)
mem_rdata_i  in  DATA_W  memory read data
cpu_stall_o  out  1  hold PC/control
dma_busy_o  out  1  DMA in progress

Behaviour:
- Reset: every output 0; state IDLE; DMA index 0, page 0, parity 0.
- States: IDLE, BUSY, DMA_ALIGN, DMA_RD, DMA_RD_WAIT, DMA_WR_WAIT.
- IDLE arbitration at each edge, fixed priority: pending DMA > LS > FE. Winner's gnt pulses high in the cycle after the edge. mem_req_o/we/addr/wdata are registered from the winner in that same cycle. Go to BUSY.
- Special case: LS write with ls_addr_i==DMA_REG_ADDR. ls_gnt_o pulses, no memory access, page <= ls_wdata_i, go to DMA_ALIGN. cpu_stall_o and dma_busy_o go high in that cycle.
- BUSY: mem outputs held stable until an edge samples mem_valid_i=1. At that edge: mem_req_o<=0; for reads rdata_o<=mem_rdata_i and the owner's rvalid pulses next cycle; return to IDLE.
- Min cost is 2 cycles per access; back-to-back FE fetches are granted every 2 cycles.
- Losing requester keeps req asserted and is served later. No starvation guarantee for FE during continuous LS.
- DMA sequence:
  - DMA_ALIGN: 1 idle cycle.
  - Per byte i=0..DMA_LEN-1: read {page,i[7:0]} (DMA_RD_WAIT until mem_valid_i), latch byte, then write to OAM_DATA_ADDR (DMA_WR_WAIT until mem_valid_i).
  - DMA reads never assert fe/ls_rvalid_o.
  - After write i=DMA_LEN-1 completes: IDLE; cpu_stall_o and dma_busy_o drop next cycle. Index wraps to 0.
- FE/LS requests during DMA receive no gnt.
- mem_valid_i is ignored while mem_req_o=0.
- Reset asserted mid-transaction or mid-DMA: immediate return to reset values. The DMA is abandoned, not resumed.
- Free-running parity bit toggles every cycle from reset.

Optional Feature:
- OAM_DMA_ALIGN_EN defined: if parity==1 in the first DMA_ALIGN cycle, stay in DMA_ALIGN one extra cycle (NES odd-cycle alignment).
- Not defined: exactly one DMA_ALIGN cycle; parity bit not implemented.

Test Plan:
- FE read 0x8000, mem returns 0xA9 with zero wait -> fe_gnt_o at cycle 1, mem_req_o cycles 1, fe_rvalid_o cycle 2 with rdata_o=0xA9.
- FE and LS read (0x0010) requested same edge -> ls_gnt_o first, mem_addr_o=0x0010; FE granted 2 cycles later.
- LS write 0x55 to 0x0200 with mem_valid_i delayed 3 cycles -> mem outputs stable 4 cycles, no ls_rvalid_o, IDLE after.
- LS write 0x02 to 0x4014, memory returns addr[7:0] -> dma_busy_o high, 256 reads 0x0200..0x02FF each followed by write to 0x2004 with same byte; stall drops after last write.
- FE request during DMA -> no fe_gnt_o until DMA ends, then granted in the next arbitration.
- rstn_i low at DMA byte 100 -> all outputs 0 asynchronously; after release, FE read served normally, no DMA resumes.
